uart_rx_engine: RTL and testbench
=================================

# uart_rx_engine

Receive half of the full UART: recovers serial frames from the board RX pin and presents each byte plus status to the processor side of the core, complementing the existing transmit engine. Frame format (7/8 data bits, optional odd/even parity, one stop bit) and baud rate come from the same EIGHT/PEN/OHEL/BAUD switch inputs the transmitter uses. Instantiated inside the core beside the transmit engine, below the technology-specific I/O wrapper.

## Interface
- CLK_HZ, 100_000_000, system clock frequency; documents the divisor table, no arithmetic on it.
- SYNC_STAGES, 2, flip-flops in the RX input synchronizer, minimum 2.

Ports:
- clk  in  1  system clock; one clock for the whole block.
- rst  in  1  reset; asynchronous, active-low.
- EIGHT  in  1  1 = 8 data bits, 0 = 7 data bits.
- PEN  in  1  1 = parity bit present.
- OHEL  in  1  parity sense: 1 = odd, 0 = even.
- BAUD  in  4  baud-rate select.
- RX  in  1  asynchronous serial input, idle high.
- READ  in  1  one-cycle pulse: processor consumed DATA.
- DATA  out  8  received byte; bit 7 forced 0 in 7-bit mode.
- RXRDY  out  1  byte available.
- PERR  out  1  parity error on the last frame.
- FERR  out  1  framing error (stop bit sampled 0) on the last frame.
- OVF  out  1  overrun: frame completed while RXRDY was still 1.

## Operation
- Reset: DATA=0, RXRDY=0, PERR=0, FERR=0, OVF=0, state IDLE, synchronizer flops preset to 1.
- Bit time N from BAUD: 0:333333, 1:83333, 2:41667, 3:20833, 4:10417, 5:5208, 6:2604, 7:1736, 8:868, 9:434, A:217, B:109, C–F:109. Half time = N>>1.
- EIGHT, PEN, OHEL, BAUD are captured on start detect and held for the whole frame; mid-frame changes apply from the next frame.
- Frame bit count after start: 7 + EIGHT + PEN data/parity bits, then stop.
- States:
  - IDLE: synced RX=0 → START, bit-time counter cleared.
  - START: at half bit time, RX=0 → DATA; RX=1 → IDLE (glitch rejected, no output change).
  - DATA: every full bit time, sample RX; data bits stored LSB first at index 0..6/7; if PEN, last sample is the parity bit. After the final sample → STOP.
  - STOP: after a full bit time sample RX; complete the frame; → IDLE. RX=0 at stop still completes with FERR=1; IDLE then waits for RX high→low (no re-detect while line held low).
- Completion (one cycle): DATA loaded, RXRDY←1, PERR←PEN & (XOR(data bits, parity bit) ≠ OHEL), FERR←~stop sample, OVF←OVF | (RXRDY & ~READ).
- READ (not coincident with completion): RXRDY←0, OVF←0; DATA, PERR, FERR hold.
- READ coincident with completion: new frame wins, RXRDY stays 1, OVF not set.
- Asynchronous reset mid-frame: frame discarded, outputs to reset values immediately.

## Timing
- RX synchronizer latency SYNC_STAGES cycles; all sample points referenced to the synchronized signal.
- Start detect to start check: N>>1 cycles; each subsequent sample exactly N cycles after the previous.
- RXRDY/DATA/PERR/FERR/OVF update one clk after the stop-bit sample edge, all registered, no combinational path from inputs to outputs.
- READ effect visible the cycle after the READ pulse.
- Bit-time counter width 19 bits (fits 333333); counter reloads, never wraps.

## Structure
- Shared package uart_pkg: state enum (IDLE, START, DATA, STOP), BAUD→divisor function/table, shared with the transmit engine so both ends use identical bit times.
- One sub-module natural: uart_rx_bit_timer (bit-time counter emitting half-bit and full-bit ticks from the captured divisor, clear input from the FSM).
- Synchronizer and FSM/shift/status logic stay in the top of this block.

## Test plan
- 8N1, BAUD=8 (N=868): send 0xA5 → RXRDY rises, DATA=0xA5, PERR=FERR=OVF=0; READ pulse → RXRDY=0 next cycle.
- 7-bit, PEN=1, OHEL=1 (odd): send 0x41 with parity 1 → DATA=0x41, PERR=0; same frame with parity 0 → PERR=1.
- 8E1 frame with stop bit 0 → DATA=received byte, FERR=1, RXRDY=1; line then idles high and next 0x3C frame received cleanly with FERR=0.
- Two 8N1 frames 0x11, 0x22 with no READ → DATA=0x22, OVF=1; READ → RXRDY=0, OVF=0. Repeat with READ on the completion cycle → OVF=0, RXRDY=1.
- RX low glitch of 200 cycles at BAUD=8 → no RXRDY, state back to IDLE; assert rst mid-frame → all outputs 0 immediately, next full frame received correctly.
- Change BAUD from 8 to 4 during a frame → current frame decoded at 115200 correctly; next frame at 9600 (N=10417) decoded correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART receive and transmit engines: FSM state
// encoding and the BAUD-select to bit-time divisor mapping.
package uart_pkg;

    localparam int unsigned CNT_W = 19;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    // Bit time in system clocks at 100 MHz; selects C-F repeat the fastest rate.
    function automatic logic [CNT_W-1:0] baud_divisor(input logic [3:0] baud);
        logic [CNT_W-1:0] div;
        case (baud)
            4'h0:    div = 19'd333333;
            4'h1:    div = 19'd83333;
            4'h2:    div = 19'd41667;
            4'h3:    div = 19'd20833;
            4'h4:    div = 19'd10417;
            4'h5:    div = 19'd5208;
            4'h6:    div = 19'd2604;
            4'h7:    div = 19'd1736;
            4'h8:    div = 19'd868;
            4'h9:    div = 19'd434;
            4'hA:    div = 19'd217;
            default: div = 19'd109;
        endcase
        return div;
    endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-time counter for the receiver: emits a half-bit and a full-bit tick
// relative to the last clear, reloading on every full bit.
module uart_rx_bit_timer
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] divisor_i,
    output logic             half_tick_o,
    output logic             full_tick_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] halfLast;
    logic [CNT_W-1:0] fullLast;

    assign halfLast    = (divisor_i >> 1) - CNT_W'(1);
    assign fullLast    = divisor_i - CNT_W'(1);
    assign half_tick_o = (cnt_q == halfLast);
    assign full_tick_o = (cnt_q == fullLast);

    // Reload on a full tick so consecutive samples land exactly one bit apart.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear_i || full_tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizes RX, decodes 7/8-bit frames with optional
// parity and presents the byte with parity, framing and overrun status.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       EIGHT,
    input  logic       PEN,
    input  logic       OHEL,
    input  logic [3:0] BAUD,
    input  logic       RX,
    input  logic       READ,
    output logic [7:0] DATA,
    output logic       RXRDY,
    output logic       PERR,
    output logic       FERR,
    output logic       OVF
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (CLK_HZ <= 0) begin : g_bad_clk
        $error("CLK_HZ must be positive");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxSync;
    logic                   rxPrev_q;
    uart_state_e            state_q;
    logic [CNT_W-1:0]       div_q;
    logic                   eight_q;
    logic                   pen_q;
    logic                   ohel_q;
    logic [3:0]             lastIdx_q;
    logic [3:0]             bitIdx_q;
    logic [8:0]             frame_q;
    logic [7:0]             data_q;
    logic                   rxrdy_q;
    logic                   perr_q;
    logic                   ferr_q;
    logic                   ovf_q;

    logic       halfTick;
    logic       fullTick;
    logic       timerClear;
    logic       startEdge;
    logic [7:0] frameData;
    logic       parityBit;
    logic       parityErr;

    assign rxSync     = sync_q[SYNC_STAGES-1];
    assign startEdge  = rxPrev_q & ~rxSync;
    assign timerClear = (state_q == ST_IDLE) || ((state_q == ST_START) && halfTick);

    // In 7-bit mode the parity bit lands at index 7, so mask it out of the byte.
    assign frameData = eight_q ? frame_q[7:0] : {1'b0, frame_q[6:0]};
    assign parityBit = eight_q ? frame_q[8] : frame_q[7];
    assign parityErr = pen_q & ((^frameData ^ parityBit) != ohel_q);

    assign DATA  = data_q;
    assign RXRDY = rxrdy_q;
    assign PERR  = perr_q;
    assign FERR  = ferr_q;
    assign OVF   = ovf_q;

    uart_rx_bit_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (timerClear),
        .divisor_i   (div_q),
        .half_tick_o (halfTick),
        .full_tick_o (fullTick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '1;
            rxPrev_q  <= 1'b1;
            state_q   <= ST_IDLE;
            div_q     <= '0;
            eight_q   <= 1'b0;
            pen_q     <= 1'b0;
            ohel_q    <= 1'b0;
            lastIdx_q <= '0;
            bitIdx_q  <= '0;
            frame_q   <= '0;
            data_q    <= '0;
            rxrdy_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], RX};
            rxPrev_q <= rxSync;

            if (READ) begin
                rxrdy_q <= 1'b0;
                ovf_q   <= 1'b0;
            end

            case (state_q)
                // A falling edge is required, so a line stuck low is not re-detected.
                ST_IDLE: begin
                    if (startEdge) begin
                        state_q   <= ST_START;
                        div_q     <= baud_divisor(BAUD);
                        eight_q   <= EIGHT;
                        pen_q     <= PEN;
                        ohel_q    <= OHEL;
                        lastIdx_q <= 4'd6 + {3'b000, EIGHT} + {3'b000, PEN};
                        bitIdx_q  <= '0;
                        frame_q   <= '0;
                    end
                end
                ST_START: begin
                    if (halfTick) begin
                        state_q <= rxSync ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (fullTick) begin
                        frame_q[bitIdx_q] <= rxSync;
                        if (bitIdx_q == lastIdx_q) begin
                            state_q <= ST_STOP;
                        end else begin
                            bitIdx_q <= bitIdx_q + 4'd1;
                        end
                    end
                end
                // Completion overrides a coincident READ: the new frame stays pending.
                ST_STOP: begin
                    if (fullTick) begin
                        state_q <= ST_IDLE;
                        data_q  <= frameData;
                        rxrdy_q <= 1'b1;
                        perr_q  <= parityErr;
                        ferr_q  <= ~rxSync;
                        ovf_q   <= ovf_q | (rxrdy_q & ~READ);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine: expected frames are queued at stimulus
// time and popped by a monitor whenever the receiver presents a new result.
module tb_uart_rx_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       EIGHT;
    logic       PEN;
    logic       OHEL;
    logic [3:0] BAUD;
    logic       RX;
    logic       READ;
    logic [7:0] DATA;
    logic       RXRDY;
    logic       PERR;
    logic       FERR;
    logic       OVF;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovf;
    } expect_t;

    expect_t expQ[$];
    int      errors = 0;
    int      checks = 0;

    always #5 clk = ~clk;

    uart_rx_engine #(
        .CLK_HZ      (100_000_000),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .EIGHT (EIGHT),
        .PEN   (PEN),
        .OHEL  (OHEL),
        .BAUD  (BAUD),
        .RX    (RX),
        .READ  (READ),
        .DATA  (DATA),
        .RXRDY (RXRDY),
        .PERR  (PERR),
        .FERR  (FERR),
        .OVF   (OVF)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectFrame(input logic [7:0] d, input logic p, input logic f, input logic o);
        expQ.push_back({d, p, f, o});
    endtask

    // Serial frame: start, nbits payload bits LSB first, stop, then one idle bit time.
    task automatic applyStimulus(input logic [8:0] bits, input int nbits, input logic stopBit,
                                 input int n, input bit midChange, input logic [3:0] midBaud);
        RX = 1'b0;
        repeat (n) @(negedge clk);
        if (midChange) BAUD = midBaud;
        for (int i = 0; i < nbits; i++) begin
            RX = bits[i];
            repeat (n) @(negedge clk);
        end
        RX = stopBit;
        repeat (n) @(negedge clk);
        RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulseRead();
        @(negedge clk);
        READ = 1'b1;
        @(negedge clk);
        READ = 1'b0;
        checkOutput("rxrdy_after_read", 32'(RXRDY), 32'(0));
    endtask

    initial begin
        rst   = 1'b0;
        RX    = 1'b1;
        READ  = 1'b0;
        EIGHT = 1'b1;
        PEN   = 1'b0;
        OHEL  = 1'b0;
        BAUD  = 4'h8;

        fork
            begin : monitor
                logic [11:0] prevSnap;
                logic [11:0] snap;
                expect_t     e;
                prevSnap = '0;
                forever begin
                    @(negedge clk);
                    snap = {RXRDY, DATA, PERR, FERR, OVF};
                    if (RXRDY && (snap != prevSnap)) begin
                        if (expQ.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_output: got data=0x%0h perr=%0b ferr=%0b ovf=%0b, expected no frame",
                                     DATA, PERR, FERR, OVF);
                        end else begin
                            e = expQ.pop_front();
                            checkOutput("frame_output", 32'({DATA, PERR, FERR, OVF}), 32'(e));
                        end
                    end
                    prevSnap = snap;
                end
            end
        join_none

        repeat (5) @(negedge clk);
        checkOutput("reset_data",  32'(DATA),  32'(0));
        checkOutput("reset_rxrdy", 32'(RXRDY), 32'(0));
        checkOutput("reset_perr",  32'(PERR),  32'(0));
        checkOutput("reset_ferr",  32'(FERR),  32'(0));
        checkOutput("reset_ovf",   32'(OVF),   32'(0));
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // 8N1 at the 868-cycle bit time
        expectFrame(8'hA5, 1'b0, 1'b0, 1'b0);
        applyStimulus(9'h0A5, 8, 1'b1, 868, 1'b0, 4'h0);
        pulseRead();

        // 7 data bits, odd parity; 0x41 has two ones so the correct parity bit is 1
        BAUD = 4'hB; EIGHT = 1'b0; PEN = 1'b1; OHEL = 1'b1;
        expectFrame(8'h41, 1'b0, 1'b0, 1'b0);
        applyStimulus({1'b0, 1'b1, 7'h41}, 8, 1'b1, 109, 1'b0, 4'h0);
        pulseRead();
        expectFrame(8'h41, 1'b1, 1'b0, 1'b0);
        applyStimulus({1'b0, 1'b0, 7'h41}, 8, 1'b1, 109, 1'b0, 4'h0);
        pulseRead();

        // 8E1 with a low stop bit, then a clean frame
        EIGHT = 1'b1; OHEL = 1'b0;
        expectFrame(8'h5A, 1'b0, 1'b1, 1'b0);
        applyStimulus({1'b0, 8'h5A}, 9, 1'b0, 109, 1'b0, 4'h0);
        pulseRead();
        checkOutput("ferr_held_after_read", 32'(FERR), 32'(1));
        checkOutput("data_held_after_read", 32'(DATA), 32'(8'h5A));
        expectFrame(8'h3C, 1'b0, 1'b0, 1'b0);
        applyStimulus({1'b0, 8'h3C}, 9, 1'b1, 109, 1'b0, 4'h0);
        pulseRead();

        // Overrun: two frames with no READ in between
        PEN = 1'b0;
        expectFrame(8'h11, 1'b0, 1'b0, 1'b0);
        applyStimulus(9'h011, 8, 1'b1, 109, 1'b0, 4'h0);
        expectFrame(8'h22, 1'b0, 1'b0, 1'b1);
        applyStimulus(9'h022, 8, 1'b1, 109, 1'b0, 4'h0);
        pulseRead();
        checkOutput("ovf_after_read", 32'(OVF), 32'(0));

        // READ on the completion edge: 2 sync + 1 detect + half bit + 9 bit times
        expectFrame(8'h33, 1'b0, 1'b0, 1'b0);
        applyStimulus(9'h033, 8, 1'b1, 109, 1'b0, 4'h0);
        expectFrame(8'h44, 1'b0, 1'b0, 1'b0);
        fork
            applyStimulus(9'h044, 8, 1'b1, 109, 1'b0, 4'h0);
            begin
                repeat (2 + 54 + 9 * 109) @(negedge clk);
                READ = 1'b1;
                @(negedge clk);
                READ = 1'b0;
            end
        join
        checkOutput("rxrdy_kept_on_coincident_read", 32'(RXRDY), 32'(1));
        checkOutput("ovf_clear_on_coincident_read",  32'(OVF),   32'(0));
        pulseRead();

        // Short low glitch must be rejected at the half-bit check
        BAUD = 4'h8;
        RX = 1'b0;
        repeat (200) @(negedge clk);
        RX = 1'b1;
        repeat (2000) @(negedge clk);
        checkOutput("glitch_no_rxrdy", 32'(RXRDY), 32'(0));

        // Asynchronous reset in the middle of a frame with a result pending
        BAUD = 4'hB;
        expectFrame(8'h5A, 1'b0, 1'b0, 1'b0);
        applyStimulus(9'h05A, 8, 1'b1, 109, 1'b0, 4'h0);
        RX = 1'b0;
        repeat (300) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midreset_data",  32'(DATA),  32'(0));
        checkOutput("midreset_rxrdy", 32'(RXRDY), 32'(0));
        checkOutput("midreset_perr",  32'(PERR),  32'(0));
        checkOutput("midreset_ferr",  32'(FERR),  32'(0));
        checkOutput("midreset_ovf",   32'(OVF),   32'(0));
        RX = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        expectFrame(8'h96, 1'b0, 1'b0, 1'b0);
        applyStimulus(9'h096, 8, 1'b1, 109, 1'b0, 4'h0);
        pulseRead();

        // BAUD changes mid-frame: current frame keeps its captured rate
        BAUD = 4'hB;
        expectFrame(8'hC3, 1'b0, 1'b0, 1'b0);
        applyStimulus(9'h0C3, 8, 1'b1, 109, 1'b1, 4'h8);
        pulseRead();
        expectFrame(8'h69, 1'b0, 1'b0, 1'b0);
        applyStimulus(9'h069, 8, 1'b1, 868, 1'b0, 4'h0);
        pulseRead();

        for (int i = 0; i < 5000 && expQ.size() != 0; i++) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
